split_3: RTL and testbench

Clocked 1-to-3 request/acknowledge splitter that steers one upstream transaction to exactly one of three downstream channels, selected by RISC-V opcode class. It is the counterpart of the 3-to-1 merge stage: it sits at the issue side of the same handshake network and fans a decoded instruction out to the branch/jump path (1), the store path (2) or the ALU/load path (3). It collects the chosen channel's acknowledge and returns a single acknowledge upstream. All handshakes are four-phase (return-to-zero) on one clock.

---
 rtl/split_pkg.sv | 28 ++
 rtl/opcode_route.sv | 21 ++
 rtl/split_3.sv | 120 ++++++++++++
 tb/tb_split_3.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/split_pkg.sv
// Shared definitions for the issue-side splitter and the merge stage.
// Holds the opcode constants and the route/state enumerations.
package split_pkg;

  localparam logic [6:0] OP_B_TYPE    = 7'b1100011;
  localparam logic [6:0] OP_J_TYPE    = 7'b1101111;
  localparam logic [6:0] OP_S_TYPE    = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE    = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE_OP = 7'b0010011;
  localparam logic [6:0] OP_I_TYPE_LD = 7'b0000011;
  localparam logic [6:0] OP_U_TYPE    = 7'b0110111;
  localparam logic [6:0] OP_NOP       = 7'b0000000;

  typedef enum logic [1:0] {
    ROUTE_1   = 2'd0,
    ROUTE_2   = 2'd1,
    ROUTE_3   = 2'd2,
    ROUTE_ILL = 2'd3
  } route_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/opcode_route.sv
// Combinational opcode-class decoder: branch/jump, store, ALU/load or unroutable.
module opcode_route
  import split_pkg::*;
(
  input  logic [6:0] opcode,
  output route_t     route
);

  // Map each recognised opcode class onto its downstream channel
  always_comb begin
    route = ROUTE_ILL;
    case (opcode)
      OP_B_TYPE, OP_J_TYPE:                 route = ROUTE_1;
      OP_S_TYPE:                            route = ROUTE_2;
      OP_R_TYPE, OP_I_TYPE_OP, OP_I_TYPE_LD,
      OP_U_TYPE, OP_NOP:                    route = ROUTE_3;
      default:                              route = ROUTE_ILL;
    endcase
  end

endmodule

// File: rtl/split_3.sv
// Four-phase 1-to-3 request/acknowledge splitter steered by opcode class.
// Unroutable opcodes are acknowledged without a downstream request and flagged.
module split_3
  import split_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              req_in,
  output logic              ack_out,
  output logic              req_out_1,
  output logic              req_out_2,
  output logic              req_out_3,
  input  logic              ack_in_1,
  input  logic              ack_in_2,
  input  logic              ack_in_3,
  output logic [DATA_W-1:0] data_out,
  output logic              err_illegal
);

  state_t state_r;
  state_t state_nx_s;
  route_t sel_r;
  route_t sel_nx_s;
  route_t route_s;
  logic   ack_sel_s;
  logic   latch_s;

  opcode_route u_route (
    .opcode (opcode),
    .route  (route_s)
  );

  // Acknowledge of the currently selected channel; others are ignored
  always_comb begin
    ack_sel_s = 1'b0;
    case (sel_r)
      ROUTE_1: ack_sel_s = ack_in_1;
      ROUTE_2: ack_sel_s = ack_in_2;
      ROUTE_3: ack_sel_s = ack_in_3;
      default: ack_sel_s = 1'b0;
    endcase
  end

  // Next-state and channel-select logic of the handshake FSM
  always_comb begin
    state_nx_s = state_r;
    sel_nx_s   = sel_r;
    latch_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_in) begin
          latch_s  = 1'b1;
          sel_nx_s = route_s;
          if (route_s == ROUTE_ILL) begin
            state_nx_s = RESP;
          end else begin
            state_nx_s = FWD;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      FWD: begin
        if (ack_sel_s) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = FWD;
        end
      end
      DRAIN: begin
        if (!ack_sel_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      RESP: begin
        if (!req_in) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, select, payload and flag registers; outputs are decoded from the
  // next state so that they change on the same edge as the state itself
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sel_r       <= ROUTE_ILL;
      data_out    <= {DATA_W{1'b0}};
      err_illegal <= 1'b0;
      req_out_1   <= 1'b0;
      req_out_2   <= 1'b0;
      req_out_3   <= 1'b0;
      ack_out     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      sel_r   <= sel_nx_s;
      if (latch_s) begin
        data_out <= data_in;
      end
      if (latch_s && (route_s == ROUTE_ILL)) begin
        err_illegal <= 1'b1;
      end
      req_out_1 <= (state_nx_s == FWD) && (sel_nx_s == ROUTE_1);
      req_out_2 <= (state_nx_s == FWD) && (sel_nx_s == ROUTE_2);
      req_out_3 <= (state_nx_s == FWD) && (sel_nx_s == ROUTE_3);
      ack_out   <= (state_nx_s == RESP);
    end
  end

endmodule

// File: tb/tb_split_3.sv
// Self-checking bench for split_3: a table of opcode vectors, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_split_3;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [31:0] data_in;
  logic        req_in;
  logic        ack_out;
  logic        req_out_1, req_out_2, req_out_3;
  logic [3:1]  ack_v;
  logic [31:0] data_out;
  logic        err_illegal;

  int errors = 0;
  int checks = 0;
  logic err_exp = 1'b0;

  split_3 #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .data_in     (data_in),
    .req_in      (req_in),
    .ack_out     (ack_out),
    .req_out_1   (req_out_1),
    .req_out_2   (req_out_2),
    .req_out_3   (req_out_3),
    .ack_in_1    (ack_v[1]),
    .ack_in_2    (ack_v[2]),
    .ack_in_3    (ack_v[3]),
    .data_out    (data_out),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] data;
    int          ch;
  } vec_t;

  vec_t tbl[12];

  // Channel from the opcode classes: 1 branch/jump, 2 store, 3 ALU/load, 0 unroutable
  function automatic int ref_route(input logic [6:0] op);
    case (op)
      7'b1100011, 7'b1101111: return 1;
      7'b0100011:             return 2;
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0000000: return 3;
      default:                return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [2:0] exp_req, input logic exp_ack);
    chk({name, "_req"}, {29'd0, req_out_3, req_out_2, req_out_1}, {29'd0, exp_req});
    chk({name, "_ack"}, {31'd0, ack_out}, {31'd0, exp_ack});
  endtask

  // Randomly drive the acknowledges of every channel except ch
  task automatic noise(input int ch);
    for (int k = 1; k <= 3; k++) begin
      if (k != ch) ack_v[k] = 1'($urandom_range(1, 0));
    end
  endtask

  // One complete four-phase transaction with the expected timing checked per edge
  task automatic txn(input logic [6:0] op, input logic [31:0] d, input int ch,
                     input int fwd_wait, input int drain_hold, input int resp_hold);
    logic [2:0] onehot;
    onehot  = (ch == 0) ? 3'b000 : 3'(1 << (ch - 1));
    opcode  = op;
    data_in = d;
    req_in  = 1'b1;
    tick();
    opcode  = 7'($urandom);
    data_in = $urandom;
    if (ch == 0) begin
      err_exp = 1'b1;
      chk_outs("ill_e0", 3'b000, 1'b1);
    end else begin
      chk_outs("fwd_e0", onehot, 1'b0);
      for (int i = 0; i < fwd_wait; i++) begin
        noise(ch);
        tick();
        chk_outs("fwd_hold", onehot, 1'b0);
      end
      ack_v[ch] = 1'b1;
      noise(ch);
      tick();
      chk_outs("drain_e1", 3'b000, 1'b0);
      for (int i = 0; i < drain_hold; i++) begin
        noise(ch);
        tick();
        chk_outs("drain_hold", 3'b000, 1'b0);
      end
      ack_v = 3'b000;
      tick();
      chk_outs("resp", 3'b000, 1'b1);
    end
    chk("data_latch", data_out, d);
    chk("err_flag", {31'd0, err_illegal}, {31'd0, err_exp});
    for (int i = 0; i < resp_hold; i++) begin
      ack_v = 3'($urandom);
      tick();
      chk_outs("resp_hold", 3'b000, 1'b1);
    end
    ack_v  = 3'b000;
    req_in = 1'b0;
    tick();
    chk_outs("rtz", 3'b000, 1'b0);
    chk("data_hold", data_out, d);
  endtask

  initial begin
    tbl[0]  = '{7'b0110011, 32'hDEADBEEF, 3};
    tbl[1]  = '{7'b1100011, 32'h11110001, 1};
    tbl[2]  = '{7'b0100011, 32'h22220002, 2};
    tbl[3]  = '{7'b1101111, 32'h33330003, 1};
    tbl[4]  = '{7'b0010011, 32'h44440004, 3};
    tbl[5]  = '{7'b0000011, 32'h55550005, 3};
    tbl[6]  = '{7'b0110111, 32'h66660006, 3};
    tbl[7]  = '{7'b0000000, 32'h77770007, 3};
    tbl[8]  = '{7'b1111111, 32'h88880008, 0};
    tbl[9]  = '{7'b1100111, 32'h99990009, 0};
    tbl[10] = '{7'b0100011, 32'hAAAA000A, 2};
    tbl[11] = '{7'b0010111, 32'hBBBB000B, 0};

    rst     = 1'b1;
    opcode  = 7'd0;
    data_in = 32'd0;
    req_in  = 1'b0;
    ack_v   = 3'b000;
    tick();
    tick();
    chk_outs("reset", 3'b000, 1'b0);
    chk("reset_data", data_out, 32'd0);
    chk("reset_err", {31'd0, err_illegal}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].op, tbl[i].data, tbl[i].ch, (i == 2) ? 5 : i % 3, i % 2, i % 3);
    end

    // Long waits in DRAIN and RESP
    txn(7'b0110011, 32'hC0FFEE00, 3, 1, 20, 10);

    // Reset while forwarding withdraws the request and clears the sticky flag
    opcode  = 7'b0110011;
    data_in = 32'h12345678;
    req_in  = 1'b1;
    tick();
    chk_outs("pre_rst_fwd", 3'b100, 1'b0);
    rst    = 1'b1;
    req_in = 1'b0;
    tick();
    err_exp = 1'b0;
    chk_outs("mid_rst", 3'b000, 1'b0);
    chk("mid_rst_data", data_out, 32'd0);
    chk("mid_rst_err", {31'd0, err_illegal}, 32'd0);
    rst = 1'b0;
    tick();
    chk_outs("post_rst_idle", 3'b000, 1'b0);
    txn(7'b0100011, 32'h0BADF00D, 2, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      logic [6:0] legal [8];
      legal = '{7'b1100011, 7'b1101111, 7'b0100011, 7'b0110011,
                7'b0010011, 7'b0000011, 7'b0110111, 7'b0000000};
      if ($urandom_range(1, 0) == 0) op = legal[$urandom_range(7, 0)];
      else op = 7'($urandom);
      txn(op, $urandom, ref_route(op), $urandom_range(3, 0),
          $urandom_range(3, 0), $urandom_range(3, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
